decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised RV32I decode stage with an output instruction queue, sitting between fetch and execute. It accepts (pc, instruction) beats from fetch over a valid/ready handshake, then decodes each instruction combinationally in the accept cycle. Register operands are read in the same cycle with write-back bypass, and the decoded entry is pushed into a DEPTH-entry FIFO that execute drains. Unlike the previous decode stage it buffers multiple instructions, has a flush for branch redirects, flags illegal opcodes and sustains one instruction per cycle.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- ADDR_WIDTH, 32, pc width
- DATA_WIDTH, 32, register/immediate width
- REG_ADDR_WIDTH, 5, register index width
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- in_valid / in_ready  in/out  1  fetch handshake
- in_pc  in  ADDR_WIDTH  instruction address
- in_ins  in  32  instruction word
- rf_rs1_addr, rf_rs2_addr  out  REG_ADDR_WIDTH  register-file read addresses (combinational from in_ins)
- rf_rs1_data, rf_rs2_data  in  DATA_WIDTH  register-file read data, same cycle
- wb_valid  in  1  write-back this cycle
- wb_rd  in  REG_ADDR_WIDTH  write-back destination
- wb_data  in  DATA_WIDTH  write-back value
- flush  in  1  discard all queued and incoming instructions
- pause  in  1  stall intake; the queue still drains
- out_valid / out_ready  out/in  1  execute handshake
- out_entry  out  dec_entry_t  head entry: pc, opcode, rd_addr, rs1_data, rs2_data, imm, funct3, funct7, illegal
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Push condition: in_valid && in_ready. Pop condition: out_valid && out_ready.
- in_ready = ~rst && ~flush && ~pause && (count < DEPTH || out_ready). A full queue accepts when popping in the same cycle.
- Decode is combinational on in_ins:
  - opcode = in_ins[6:0]; rd, rs1 and rs2 come from the standard fields.
  - imm is sign-extended per format: I, S, B (bit0=0), U (low 12 bits zero), J (bit0=0). R-type imm = 0.
  - illegal = 1 when opcode is not one of the nine RV32I opcodes (0x37, 0x17, 0x6F, 0x67, 0x63, 0x03, 0x23, 0x13, 0x33).
  - Illegal entries are still queued; execute traps on them.
- Bypass: if wb_valid && wb_rd == rsN && rsN != 0, rsN_data = wb_data; otherwise it comes from the register file. Reads of x0 always return 0.
- The FIFO is a circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH. count is held separately.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- flush takes priority over push and pop. On the next edge rd_ptr = wr_ptr = 0 and count = 0. in_ready is low during the flush cycle, so no push occurs. The cycle after flush deasserts, intake resumes.
- pause gates pushes only; pops continue.

## Timing
- Reset values: out_valid=0, count=0, pointers=0, in_ready=0 while rst is high. Storage is not reset; out_entry is don't-care while out_valid=0.
- Latency: a push at edge N gives out_valid=1 with that entry on out_entry after edge N, so the entry is poppable in cycle N+1.
- out_valid = (count != 0), from registered state only. out_entry reads the head combinationally from registered storage.
- Throughput: 1 push and 1 pop per cycle sustained at any occupancy.
- rf_* addresses are combinational from in_ins. The register file must answer in the same cycle.
- Asserting rst mid-operation empties the queue immediately (asynchronously). Entries are lost and no partial push completes.

## Structure
- The shared package `_pkg_riscv_defines` gets:
  - opcode_t enum values for the nine opcodes
  - the dec_entry_t packed struct
  - an IMM_FMT enum
- Sub-module `rv32i_decoder` (combinational) maps ins to fields, imm and illegal. decode_queue instantiates it and holds the bypass mux, FIFO and control.
- The FIFO lives inline; it is not a separate module.

## Test plan
- **Reset and single push.** Reset, then push pc=0x100, ins=0x00500093 (addi x1,x0,5). Next cycle: out_valid=1, opcode=0x13, rd=1, imm=5, funct3=0, rs1_data=0, illegal=0.
- **Fill and wrap.** DEPTH=4, out_ready=0. Push 4 instructions; in_ready goes low and count=4. Assert out_ready and push continuously for 20 instructions. Require no stall, pc sequence preserved across pointer wrap, count stays 4.
- **Immediates and illegal opcode.** Push 0x12345137 (lui x2) -> imm=0x12345000. Push 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC. Push 0x00000000 -> illegal=1.
- **Bypass.** rf_rs1_data=0xAAAA; in the same cycle wb_valid=1, wb_rd=3, wb_data=0x55; push add x4,x3,x0. Require rs1_data=0x55. Repeat with wb_rd=0 and rs1=x0 -> rs1_data=0.
- **Flush.** With 3 entries queued, assert flush together with in_valid and out_ready for one cycle. Next cycle: count=0, out_valid=0, no entry pushed or popped; the next push is delivered normally.
- **Pause and mid-operation reset.** pause=1 with 2 entries queued -> in_ready=0 while both drain in order. Then rst pulses with 2 entries queued -> out_valid=0 immediately, count=0.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats
// and the decoded queue entry handed to execute.
package decode_queue_pkg;

  localparam int XLEN   = 32;
  localparam int AW     = 32;
  localparam int RAW    = 5;

  typedef enum logic [6:0] {
    OP_LUI    = 7'h37,
    OP_AUIPC  = 7'h17,
    OP_JAL    = 7'h6F,
    OP_JALR   = 7'h67,
    OP_BRANCH = 7'h63,
    OP_LOAD   = 7'h03,
    OP_STORE  = 7'h23,
    OP_IMM    = 7'h13,
    OP_REG    = 7'h33
  } opcode_t;

  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  typedef struct packed {
    logic [AW-1:0]   pc;
    logic [6:0]      opcode;
    logic [RAW-1:0]  rd_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            illegal;
  } dec_entry_t;

endpackage

// File: rtl/decode_queue_rv32i_decoder.sv
// Combinational RV32I field extraction, immediate
// generation and illegal-opcode detection.
module rv32i_decoder
  import decode_queue_pkg::*;
(
  input  logic [31:0]     i_ins,
  output logic [6:0]      o_opcode,
  output logic [RAW-1:0]  o_rd,
  output logic [RAW-1:0]  o_rs1,
  output logic [RAW-1:0]  o_rs2,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  imm_fmt_t w_fmt;

  assign o_opcode = i_ins[6:0];
  assign o_rd     = i_ins[11:7];
  assign o_funct3 = i_ins[14:12];
  assign o_rs1    = i_ins[19:15];
  assign o_rs2    = i_ins[24:20];
  assign o_funct7 = i_ins[31:25];

  always_comb begin
    w_fmt     = IMM_R;
    o_illegal = 1'b0;
    case (i_ins[6:0])
      OP_LUI, OP_AUIPC:         w_fmt = IMM_U;
      OP_JAL:                   w_fmt = IMM_J;
      OP_JALR, OP_LOAD, OP_IMM: w_fmt = IMM_I;
      OP_BRANCH:                w_fmt = IMM_B;
      OP_STORE:                 w_fmt = IMM_S;
      OP_REG:                   w_fmt = IMM_R;
      default:                  o_illegal = 1'b1;
    endcase
  end

  always_comb begin
    o_imm = '0;
    case (w_fmt)
      IMM_I: o_imm = {{20{i_ins[31]}}, i_ins[31:20]};
      IMM_S: o_imm = {{20{i_ins[31]}}, i_ins[31:25],
                      i_ins[11:7]};
      IMM_B: o_imm = {{19{i_ins[31]}}, i_ins[31], i_ins[7],
                      i_ins[30:25], i_ins[11:8], 1'b0};
      IMM_U: o_imm = {i_ins[31:12], 12'h000};
      IMM_J: o_imm = {{11{i_ins[31]}}, i_ins[31],
                      i_ins[19:12], i_ins[20],
                      i_ins[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// RV32I decode stage: decode + operand read with write-back
// bypass, feeding a DEPTH-entry circular queue toward execute.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_pc,
  input  logic [31:0]               in_ins,
  output logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] rf_rs2_addr,
  input  logic [DATA_WIDTH-1:0]     rf_rs1_data,
  input  logic [DATA_WIDTH-1:0]     rf_rs2_data,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic                      flush,
  input  logic                      pause,
  output logic                      out_valid,
  input  logic                      out_ready,
  output dec_entry_t                out_entry,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [6:0]            w_opcode;
  logic [RAW-1:0]        w_rd;
  logic [RAW-1:0]        w_rs1;
  logic [RAW-1:0]        w_rs2;
  logic [2:0]            w_funct3;
  logic [6:0]            w_funct7;
  logic [XLEN-1:0]       w_imm;
  logic                  w_illegal;
  logic [XLEN-1:0]       w_rs1_data;
  logic [XLEN-1:0]       w_rs2_data;
  logic                  w_push;
  logic                  w_pop;
  dec_entry_t            w_entry;

  dec_entry_t            r_mem [DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;

  rv32i_decoder u_dec (
    .i_ins     (in_ins),
    .o_opcode  (w_opcode),
    .o_rd      (w_rd),
    .o_rs1     (w_rs1),
    .o_rs2     (w_rs2),
    .o_funct3  (w_funct3),
    .o_funct7  (w_funct7),
    .o_imm     (w_imm),
    .o_illegal (w_illegal)
  );

  assign rf_rs1_addr = w_rs1;
  assign rf_rs2_addr = w_rs2;

  // x0 beats any bypass; a write-back hit beats the file
  always_comb begin
    w_rs1_data = rf_rs1_data;
    if (w_rs1 == '0)
      w_rs1_data = '0;
    else if (wb_valid && wb_rd == w_rs1)
      w_rs1_data = wb_data;
    w_rs2_data = rf_rs2_data;
    if (w_rs2 == '0)
      w_rs2_data = '0;
    else if (wb_valid && wb_rd == w_rs2)
      w_rs2_data = wb_data;
  end

  always_comb begin
    w_entry          = '0;
    w_entry.pc       = in_pc;
    w_entry.opcode   = w_opcode;
    w_entry.rd_addr  = w_rd;
    w_entry.rs1_data = w_rs1_data;
    w_entry.rs2_data = w_rs2_data;
    w_entry.imm      = w_imm;
    w_entry.funct3   = w_funct3;
    w_entry.funct7   = w_funct7;
    w_entry.illegal  = w_illegal;
  end

  assign out_valid = (r_count != '0);
  assign out_entry = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign in_ready  = ~rst & ~flush & ~pause &
                     ((r_count < CW'(DEPTH)) | out_ready);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue with hand-computed
// expected decode fields, queue order and occupancy.
module tb_decode_queue;
  import decode_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_ins;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        pause;
  logic        out_valid;
  logic        out_ready;
  dec_entry_t  out_entry;
  logic [2:0]  count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_ins      (in_ins),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flush       (flush),
    .pause       (pause),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_entry   (out_entry),
    .count       (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] pc,
                       input logic [31:0] ins);
    in_valid = 1'b1;
    in_pc    = pc;
    in_ins   = ins;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_pc = 0; in_ins = 0;
    rf_rs1_data = 0; rf_rs2_data = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    flush = 0; pause = 0; out_ready = 0;
    step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    step();

    // addi x1,x0,5 with junk on the file port for x0
    rf_rs1_data = 32'h1234;
    in_ins = 32'h00500093;
    #1;
    chk("rs1_addr_x0", 32'(rf_rs1_addr), 0);
    push1(32'h100, 32'h00500093);
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_pc", out_entry.pc, 32'h100);
    chk("addi_op", 32'(out_entry.opcode), 32'h13);
    chk("addi_rd", 32'(out_entry.rd_addr), 1);
    chk("addi_imm", out_entry.imm, 5);
    chk("addi_f3", 32'(out_entry.funct3), 0);
    chk("addi_rs1", out_entry.rs1_data, 0);
    chk("addi_ill", 32'(out_entry.illegal), 0);
    pop1();
    chk("addi_drain", 32'(count), 0);

    // fill, then stream 20 with simultaneous pop
    for (int i = 0; i < 4; i++)
      push1(32'h200 + 32'(4 * i), 32'h00500093);
    chk("full_count", 32'(count), 4);
    in_valid = 1'b1;
    #1;
    chk("full_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_pc = 32'h200 + 32'(4 * (k + 4));
      #1;
      chk("stream_ready", 32'(in_ready), 1);
      chk("stream_pc", out_entry.pc, 32'h200 + 32'(4 * k));
      step();
      chk("stream_count", 32'(count), 4);
    end
    in_valid = 1'b0;
    for (int k = 20; k < 24; k++) begin
      chk("drain_pc", out_entry.pc, 32'h200 + 32'(4 * k));
      step();
    end
    out_ready = 1'b0;
    chk("drain_count", 32'(count), 0);

    push1(32'h300, 32'h12345137);
    chk("lui_imm", out_entry.imm, 32'h12345000);
    chk("lui_op", 32'(out_entry.opcode), 32'h37);
    chk("lui_rd", 32'(out_entry.rd_addr), 2);
    pop1();
    push1(32'h304, 32'hFE000EE3);
    chk("beq_imm", out_entry.imm, 32'hFFFFFFFC);
    chk("beq_ill", 32'(out_entry.illegal), 0);
    pop1();
    push1(32'h308, 32'hFE20AC23);
    chk("sw_imm", out_entry.imm, 32'hFFFFFFF8);
    pop1();
    push1(32'h30C, 32'h008000EF);
    chk("jal_imm", out_entry.imm, 8);
    pop1();
    push1(32'h310, 32'h00000000);
    chk("zero_ill", 32'(out_entry.illegal), 1);
    chk("zero_valid", 32'(out_valid), 1);
    pop1();

    // bypass: add x4,x3,x0
    rf_rs1_data = 32'hAAAA;
    rf_rs2_data = 32'hBBBB;
    wb_valid = 1; wb_rd = 3; wb_data = 32'h55;
    in_ins = 32'h00018233;
    #1;
    chk("byp_rs1_addr", 32'(rf_rs1_addr), 3);
    push1(32'h400, 32'h00018233);
    chk("byp_rs1", out_entry.rs1_data, 32'h55);
    chk("byp_rs2_x0", out_entry.rs2_data, 0);
    chk("byp_rd", 32'(out_entry.rd_addr), 4);
    chk("byp_imm", out_entry.imm, 0);
    pop1();
    wb_valid = 0;
    push1(32'h404, 32'h00018233);
    chk("nobyp_rs1", out_entry.rs1_data, 32'hAAAA);
    pop1();
    wb_valid = 1; wb_rd = 0;
    push1(32'h408, 32'h00000233);
    chk("byp_x0", out_entry.rs1_data, 0);
    pop1();
    wb_valid = 0;

    // flush with 3 queued
    for (int i = 0; i < 3; i++)
      push1(32'h800 + 32'(4 * i), 32'h00500093);
    chk("pre_flush_cnt", 32'(count), 3);
    flush = 1; in_valid = 1; out_ready = 1;
    in_pc = 32'h900; in_ins = 32'h00500093;
    #1;
    chk("flush_in_ready", 32'(in_ready), 0);
    step();
    flush = 0; out_ready = 0;
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    step();
    in_valid = 0;
    chk("post_flush_cnt", 32'(count), 1);
    chk("post_flush_pc", out_entry.pc, 32'h900);
    pop1();

    // pause drains while intake is held off
    push1(32'hA00, 32'h00500093);
    push1(32'hA04, 32'h00500093);
    pause = 1; in_valid = 1; out_ready = 1;
    in_pc = 32'hA08;
    #1;
    chk("pause_ready", 32'(in_ready), 0);
    chk("pause_pc0", out_entry.pc, 32'hA00);
    step();
    chk("pause_pc1", out_entry.pc, 32'hA04);
    chk("pause_cnt1", 32'(count), 1);
    step();
    chk("pause_cnt0", 32'(count), 0);
    pause = 0; in_valid = 0; out_ready = 0;

    // asynchronous reset mid-cycle
    push1(32'hB00, 32'h00500093);
    push1(32'hB04, 32'h00500093);
    chk("prerst_cnt", 32'(count), 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_ready", 32'(in_ready), 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_cnt", 32'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
